// File: rtl/cache_pkg.sv
// Shared types and address/block geometry for the direct-mapped data cache.
package cache_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

   localparam int WORD_W          = 32;
   localparam int BLOCK_W         = 128;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);
   localparam int ADDR_W          = 30;
   localparam int BLK_ADDR_W      = ADDR_W - OFFSET_W;
endpackage

// File: rtl/cache_line_array.sv
// Per-line valid/dirty/tag/data storage: asynchronous read, synchronous word or block write.
module cache_line_array
   import cache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int TAG_W      = 25,
   localparam int IDX_W     = $clog2(NUM_BLOCKS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX_W-1:0]    idx,
   output logic                rd_valid,
   output logic                rd_dirty,
   output logic [TAG_W-1:0]    rd_tag,
   output logic [BLOCK_W-1:0]  rd_data,
   input  logic                word_we,
   input  logic [OFFSET_W-1:0] wr_offset,
   input  logic [WORD_W-1:0]   wr_word,
   input  logic                block_we,
   input  logic [TAG_W-1:0]    wr_tag,
   input  logic [BLOCK_W-1:0]  wr_block
);

   logic [NUM_BLOCKS-1:0] valid;
   logic [NUM_BLOCKS-1:0] dirty;
   logic [TAG_W-1:0]      tags [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    data [NUM_BLOCKS];

   // Only the status bits are cleared; tag/data are meaningless until valid is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         dirty <= '0;
      end else if (block_we) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (word_we) begin
         dirty[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (block_we) begin
         tags[idx] <= wr_tag;
         data[idx] <= wr_block;
      end else if (word_we) begin
         data[idx][int'(wr_offset)*WORD_W +: WORD_W] <= wr_word;
      end
   end

   assign rd_valid = valid[idx];
   assign rd_dirty = dirty[idx];
   assign rd_tag   = tags[idx];
   assign rd_data  = data[idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the core and 128-bit block memory.
module data_cache
   import cache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int TAG_W      = 25
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  proc_read,
   input  logic                  proc_write,
   input  logic [ADDR_W-1:0]     proc_addr,
   input  logic [WORD_W-1:0]     proc_wdata,
   output logic [WORD_W-1:0]     proc_rdata,
   output logic                  proc_stall,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [BLK_ADDR_W-1:0] mem_addr,
   output logic [BLOCK_W-1:0]    mem_wdata,
   input  logic [BLOCK_W-1:0]    mem_rdata,
   input  logic                  mem_ready
);

   localparam int IDX_W = $clog2(NUM_BLOCKS);

   state_t state, next_state;

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    req_tag;
   logic [OFFSET_W-1:0] offset;
   logic                req, hit;

   logic                rd_valid, rd_dirty;
   logic [TAG_W-1:0]    rd_tag;
   logic [BLOCK_W-1:0]  rd_data;
   logic                word_we, block_we;

   logic                  next_mem_read, next_mem_write;
   logic [BLK_ADDR_W-1:0] next_mem_addr;
   logic [BLOCK_W-1:0]    next_mem_wdata;

   assign offset  = proc_addr[OFFSET_W-1:0];
   assign idx     = proc_addr[IDX_W+OFFSET_W-1:OFFSET_W];
   assign req_tag = proc_addr[ADDR_W-1:IDX_W+OFFSET_W];
   assign req     = proc_read | proc_write;
   assign hit     = rd_valid & (rd_tag == req_tag);

   assign proc_stall = req & ((state != S_IDLE) | ~hit);
   // A simultaneous read+write is a store, so it never drives load data.
   assign proc_rdata = (state == S_IDLE && hit && proc_read && !proc_write)
                       ? rd_data[int'(offset)*WORD_W +: WORD_W] : '0;

   cache_line_array #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .TAG_W      (TAG_W)
   ) u_lines (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (idx),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .word_we   (word_we),
      .wr_offset (offset),
      .wr_word   (proc_wdata),
      .block_we  (block_we),
      .wr_tag    (req_tag),
      .wr_block  (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= next_state;
         mem_read  <= next_mem_read;
         mem_write <= next_mem_write;
         mem_addr  <= next_mem_addr;
         mem_wdata <= next_mem_wdata;
      end
   end

   // Memory-side outputs are computed one cycle ahead so they leave as registers.
   always_comb begin
      next_state     = state;
      next_mem_read  = mem_read;
      next_mem_write = mem_write;
      next_mem_addr  = mem_addr;
      next_mem_wdata = mem_wdata;
      word_we        = 1'b0;
      block_we       = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (hit) begin
                  word_we = proc_write;
               end else if (rd_valid && rd_dirty) begin
                  next_state     = S_WRITEBACK;
                  next_mem_write = 1'b1;
                  next_mem_addr  = {rd_tag, idx};
                  next_mem_wdata = rd_data;
               end else begin
                  next_state    = S_ALLOCATE;
                  next_mem_read = 1'b1;
                  next_mem_addr = {req_tag, idx};
               end
            end
         end
         S_WRITEBACK: begin
            if (mem_ready) begin
               next_state     = S_ALLOCATE;
               next_mem_write = 1'b0;
               next_mem_read  = 1'b1;
               next_mem_addr  = {req_tag, idx};
            end
         end
         S_ALLOCATE: begin
            if (mem_ready) begin
               next_state    = S_IDLE;
               next_mem_read = 1'b0;
               block_we      = 1'b1;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, reset/idle sequences, randomized traffic.
module tb_data_cache;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          proc_read = 1'b0, proc_write = 1'b0;
   logic [29:0]   proc_addr = '0;
   logic [31:0]   proc_wdata = '0;
   logic [31:0]   proc_rdata;
   logic          proc_stall;
   logic          mem_read, mem_write;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata = '0;
   logic          mem_ready = 1'b0;

   data_cache #(.NUM_BLOCKS(NB), .TAG_W(25)) dut (
      .clk(clk), .rst_n(rst_n),
      .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] init_word(input int waddr);
      return 32'h5A00_0000 ^ (waddr * 3);
   endfunction

   // ---------------- memory responder ----------------
   int  lat = 3;
   bit  noise = 1'b0;
   logic [127:0] bmem [int];

   function automatic logic [127:0] bmem_get(input int b);
      logic [127:0] v;
      if (bmem.exists(b)) return bmem[b];
      for (int i = 0; i < 4; i++) v[i*32 +: 32] = init_word(b*4 + i);
      return v;
   endfunction

   initial begin
      int cnt = 0;
      forever begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            cnt++;
            if (cnt >= lat) begin
               mem_ready = 1'b1;
               if (mem_write) bmem[int'(mem_addr)] = mem_wdata;
               else mem_rdata = bmem_get(int'(mem_addr));
               cnt = 0;
            end else begin
               mem_ready = 1'b0;
            end
         end else begin
            cnt = 0;
            mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   // ---------------- protocol monitor ----------------
   bit overlap_seen = 1'b0, unstable_seen = 1'b0;
   initial begin
      logic prev_rd = 0, prev_wr = 0;
      logic [27:0]  prev_addr = '0;
      logic [127:0] prev_wdata = '0;
      forever begin
         @(negedge clk);
         if (mem_read && mem_write) overlap_seen = 1'b1;
         if ((mem_read && prev_rd) && mem_addr != prev_addr) unstable_seen = 1'b1;
         if ((mem_write && prev_wr) && (mem_addr != prev_addr || mem_wdata != prev_wdata))
            unstable_seen = 1'b1;
         prev_rd = mem_read; prev_wr = mem_write;
         prev_addr = mem_addr; prev_wdata = mem_wdata;
      end
   end

   // ---------------- reference model ----------------
   bit          rv [NB];
   bit          rdty [NB];
   int          rt [NB];
   logic [31:0] rline [NB][4];
   logic [31:0] rmem [int];

   function automatic logic [31:0] rmem_get(input int w);
      return rmem.exists(w) ? rmem[w] : init_word(w);
   endfunction

   function automatic void ref_reset();
      for (int i = 0; i < NB; i++) begin rv[i] = 0; rdty[i] = 0; end
   endfunction

   function automatic void ref_access(input bit wr, input int a, input logic [31:0] d,
                                      input int l, output int exp_stall,
                                      output logic [31:0] exp_rd);
      int blk = a / 4;
      int ix  = blk % NB;
      int tg  = blk / NB;
      int w   = a % 4;
      exp_stall = 0;
      if (!(rv[ix] && rt[ix] == tg)) begin
         exp_stall = l + 1;
         if (rv[ix] && rdty[ix]) begin
            for (int i = 0; i < 4; i++) rmem[(rt[ix]*NB + ix)*4 + i] = rline[ix][i];
            exp_stall += l;
         end
         for (int i = 0; i < 4; i++) rline[ix][i] = rmem_get(blk*4 + i);
         rv[ix] = 1; rt[ix] = tg; rdty[ix] = 0;
      end
      if (wr) begin
         rline[ix][w] = d; rdty[ix] = 1; exp_rd = '0;
      end else begin
         exp_rd = rline[ix][w];
      end
   endfunction

   // ---------------- access driver ----------------
   int rd_first, rd_last, wr_first, wr_last;
   logic [27:0] wb_addr, alloc_addr;
   logic [31:0] wb_w1;

   task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                         input logic [31:0] d, output int stalls, output logic [31:0] rdata);
      bit done = 0;
      int n = 0;
      proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = d;
      stalls = 0; rdata = '0;
      rd_first = -1; rd_last = -1; wr_first = -1; wr_last = -1;
      wb_addr = '0; alloc_addr = '0; wb_w1 = '0;
      while (!done) begin
         @(negedge clk);
         if (mem_write) begin
            if (wr_first < 0) begin wr_first = n; wb_addr = mem_addr; wb_w1 = mem_wdata[63:32]; end
            wr_last = n;
         end
         if (mem_read) begin
            if (rd_first < 0) begin rd_first = n; alloc_addr = mem_addr; end
            rd_last = n;
         end
         if (!proc_stall) begin
            rdata = proc_rdata;
            done = 1;
         end else begin
            stalls++;
            n++;
            if (n > 300) begin
               errors++;
               $display("FAIL access_timeout addr=%0h stalls=%0d required<=300", a, stalls);
               done = 1;
            end
         end
      end
      @(posedge clk); #1;
      proc_read = 0; proc_write = 0;
   endtask

   typedef struct packed {
      bit          rd;
      bit          wr;
      logic [29:0] addr;
      logic [31:0] wdata;
      int          exp_stall;
      logic [31:0] exp_rdata;
      bit          chk_clean;
      bit          chk_wb;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int st, es;
      logic [31:0] rdv, er;

      tbl[0] = '{1, 0, 30'h010, 32'h0,        4, init_word(30'h010), 1, 0};
      tbl[1] = '{0, 1, 30'h011, 32'hDEADBEEF, 0, 32'h0,              0, 0};
      tbl[2] = '{1, 0, 30'h011, 32'h0,        0, 32'hDEADBEEF,       0, 0};
      tbl[3] = '{1, 0, 30'h111, 32'h0,        7, init_word(30'h111), 0, 1};
      tbl[4] = '{0, 1, 30'h022, 32'h12345678, 4, 32'h0,              1, 0};
      tbl[5] = '{1, 0, 30'h022, 32'h0,        0, 32'h12345678,       0, 0};
      tbl[6] = '{1, 0, 30'h020, 32'h0,        0, init_word(30'h020), 0, 0};
      tbl[7] = '{1, 0, 30'h021, 32'h0,        0, init_word(30'h021), 0, 0};
      tbl[8] = '{1, 0, 30'h023, 32'h0,        0, init_word(30'h023), 0, 0};
      tbl[9] = '{1, 0, 30'h011, 32'h0,        4, 32'hDEADBEEF,       1, 0};

      ref_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_mem_read",   mem_read,   0);
      check("reset_mem_write",  mem_write,  0);
      check("reset_mem_addr",   mem_addr,   0);
      check("reset_mem_wdata",  mem_wdata,  0);
      check("reset_stall",      proc_stall, 0);
      check("reset_rdata",      proc_rdata, 0);
      @(posedge clk); #1;

      // directed vectors
      lat = 3;
      for (int i = 0; i < 10; i++) begin
         access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, st, rdv);
         ref_access(tbl[i].wr, int'(tbl[i].addr), tbl[i].wdata, lat, es, er);
         check($sformatf("vec%0d_stall", i), st, tbl[i].exp_stall);
         if (tbl[i].rd) check($sformatf("vec%0d_rdata", i), rdv, tbl[i].exp_rdata);
         if (tbl[i].chk_clean) begin
            check($sformatf("vec%0d_rd_first", i), rd_first, 1);
            check($sformatf("vec%0d_rd_last", i), rd_last, tbl[i].exp_stall - 1);
            check($sformatf("vec%0d_no_wb", i), wr_first, -1);
            check($sformatf("vec%0d_alloc_addr", i), alloc_addr, tbl[i].addr[29:2]);
         end
         if (tbl[i].chk_wb) begin
            check("wb_first", wr_first, 1);
            check("wb_addr", wb_addr, 28'h4);
            check("wb_word1", wb_w1, 32'hDEADBEEF);
            check("wb_to_alloc_gap", rd_first, wr_last + 1);
            check("alloc_addr", alloc_addr, 28'h44);
         end
      end

      // reset while a refill is outstanding
      begin
         int waited = 0;
         lat = 20;
         proc_read = 1; proc_addr = 30'h030;
         @(negedge clk);
         while (!mem_read && waited < 10) begin @(negedge clk); waited++; end
         check("rstmid_mem_read_rose", mem_read, 1);
         #2 rst_n = 1'b0;
         proc_read = 0;
         #1;
         check("rstmid_mem_read_async", mem_read, 0);
         check("rstmid_mem_addr", mem_addr, 0);
         ref_reset();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         @(posedge clk); #1;
         lat = 3;
         access(1, 0, 30'h011, 32'h0, st, rdv);
         ref_access(0, 30'h011, 32'h0, lat, es, er);
         check("rstmid_reload_stall", st, 4);
         check("rstmid_reload_rdata", rdv, 32'hDEADBEEF);
      end

      // idle with stray mem_ready pulses
      noise = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("idle%0d_stall", c), proc_stall, 0);
         check($sformatf("idle%0d_rw", c), {mem_read, mem_write}, 2'b00);
      end
      noise = 1'b0;
      @(posedge clk); #1;
      access(1, 0, 30'h011, 32'h0, st, rdv);
      ref_access(0, 30'h011, 32'h0, lat, es, er);
      check("idle_after_hit_stall", st, 0);
      check("idle_after_hit_rdata", rdv, 32'hDEADBEEF);

      // randomized traffic against the reference model
      for (int k = 0; k < 80; k++) begin
         int  a;
         bit  w, r;
         logic [31:0] d;
         a = $urandom_range(0, 3) * 32 + $urandom_range(0, NB-1) * 4 + $urandom_range(0, 3);
         w = 1'($urandom_range(0, 1));
         r = w ? 1'($urandom_range(0, 1)) : 1'b1;
         d = $urandom;
         lat = $urandom_range(1, 4);
         access(r, w, 30'(a), d, st, rdv);
         ref_access(w, a, d, lat, es, er);
         check($sformatf("rnd%0d_stall a=%0h", k, a), st, es);
         check($sformatf("rnd%0d_rdata a=%0h", k, a), rdv, er);
      end

      check("mem_rw_overlap", overlap_seen, 0);
      check("mem_req_stable", unstable_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout time=%0t required<200000", $time);
      $fatal(1, "bench timeout");
   end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the MIPS core's load/store port and the 128-bit slow data memory inside CHIP. Word accesses hit with zero stall. Misses stall the core while the block is refilled from memory. A dirty victim is written back first.

## Interface
- NUM_BLOCKS, 8, number of cache lines. Power of two. Index width IDX_W = log2(NUM_BLOCKS).
- TAG_W, 25, tag width. Must equal 30 - 2 - IDX_W.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- proc_read  in  1  core load request; held until the stall is released.
- proc_write  in  1  core store request; held until the stall is released.
- proc_addr  in  30  word address: [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data. Valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  combinational. High while the current request cannot complete this cycle.
- mem_read  out  1  registered block-read request.
- mem_write  out  1  registered block-write request.
- mem_addr  out  28  registered block address {tag,index}.
- mem_wdata  out  128  registered victim block. Word 0 is in [31:0].
- mem_rdata  in  128  refill block. Sampled only when mem_ready=1.
- mem_ready  in  1  memory completion pulse for the outstanding request.

## Operation
- Storage per line: valid, dirty, tag, four 32-bit words.
- Hit: valid[idx] and tag[idx]==addr tag.
- States:
  - IDLE/COMPARE:
    - Hit load: proc_rdata = word[offset], stall low.
    - Hit store: the word is written at the edge, dirty=1, stall low.
    - Miss on a clean or invalid line: go to ALLOCATE.
    - Miss on a dirty line: go to WRITEBACK.
  - WRITEBACK:
    - mem_write=1, mem_addr={victim tag,idx}, mem_wdata=victim block.
    - On mem_ready: mem_write drops, go to ALLOCATE.
  - ALLOCATE:
    - mem_read=1, mem_addr={req tag,idx}.
    - On mem_ready: line is loaded from mem_rdata, valid=1, dirty=0, tag written, mem_read drops, go to IDLE.
    - The held request then hits. A store merges on that hit cycle.
- proc_stall = (proc_read|proc_write) & (state!=IDLE | ~hit).
- No request: no state change, stall=0.
- proc_read and proc_write both high: treated as a store. A load must not be issued alongside a store.
- mem_read and mem_write are never high together.
- mem_addr and mem_wdata are stable for the whole request.
- Reset values:
  - State IDLE.
  - All valid=0, all dirty=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - proc_rdata=0 whenever there is no hit load.
- Reset mid-refill or mid-writeback: the outstanding request is dropped immediately, all lines are invalidated, and dirty data is lost.
- mem_ready while in IDLE is ignored.

## Timing
- Hit: 0 stall cycles; the result is available in the request cycle.
- Clean miss, request in cycle 0:
  - mem_read is high from cycle 1 until the cycle k in which mem_ready=1.
  - stall is high in cycles 0..k.
  - The request completes in cycle k+1.
- Dirty miss:
  - mem_write is high in cycles 1..j, where mem_ready arrives in cycle j.
  - mem_read is high in cycles j+1..k.
  - The request completes in cycle k+1.
- The transition from WRITEBACK to ALLOCATE is back-to-back. There is no idle gap between mem_write falling and mem_read rising.

## Structure
- Shared package `cache_pkg` holds:
  - the state enum (S_IDLE, S_WRITEBACK, S_ALLOCATE);
  - the block width constant (128);
  - the words-per-block constant (4);
  - address field helper constants.
- One sub-module, `cache_line_array`: valid/dirty/tag/data storage.
  - Asynchronous read by index.
  - Synchronous word write and full-block write.
  - Asynchronous clear on rst_n.
- The FSM and the hit logic stay in `data_cache`.

## Test plan
- Cold load at 0x00000010, mem_ready returned 3 cycles after mem_read rises:
  - mem_addr=0x0000004, stall high for 4 cycles;
  - then proc_rdata = word 0 of the returned block.
- Store 0xDEADBEEF to 0x00000011, then load 0x00000011: both hit with zero stall, and the load returns 0xDEADBEEF.
- Conflict load at 0x00000111 (same index, different tag) after the dirty store:
  - writeback with mem_addr=0x0000004 and mem_wdata[63:32]=0xDEADBEEF;
  - then mem_read with mem_addr=0x0000044;
  - mem_read and mem_write never overlap.
- Store miss to a clean line at 0x00000022:
  - refill, then merge;
  - a following load returns the stored value, and the other 3 words come from memory.
- rst_n pulsed low during ALLOCATE:
  - mem_read drops asynchronously;
  - the next load to the previously cached address misses.
- proc_read=proc_write=0 for 10 cycles with random mem_ready pulses: no state change, stall=0, mem_read/mem_write stay 0.
